// File: rtl/pnd_arbiter_if.sv
// pnd_arbiter_if: requester and response handshake bundle for pnd_arbiter
interface pnd_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
);
  localparam int ID_W = $clog2(N_REQ);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [3*N_REQ-1:0] req_value;
  logic rsp_valid;
  logic rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [2:0] rsp_value;
  logic rsp_prime;
  logic [CNT_W-1:0] eval_count;
  logic [CNT_W-1:0] prime_count;
  modport master (
    output req_valid, req_value, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_value, rsp_prime, eval_count, prime_count
  );
  modport slave (
    input  req_valid, req_value, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_value, rsp_prime, eval_count, prime_count
  );
endinterface

// File: rtl/pnd_arbiter.sv
// pnd_arbiter: round-robin sharing of one 3-bit prime detector between N_REQ requesters
module pnd_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  pnd_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
  state_t state;
  logic [ID_W-1:0] ptr, win, op_id;
  logic [2:0] op_val, win_val;
  logic prime;
  // descending k so the nearest valid requester at or after ptr wins
  always_comb begin
    win = ptr;
    win_val = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      for (int i = 0; i < N_REQ; i++)
        if (i == (int'(ptr) + k) % N_REQ && bus.req_valid[i]) win = ID_W'(i);
    for (int i = 0; i < N_REQ; i++)
      if (win == ID_W'(i)) win_val = bus.req_value[3*i +: 3];
  end
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      bus.req_ready[i] = rst_n && state == IDLE && bus.req_valid[i] && win == ID_W'(i);
  end
  // detector: a=bit0, b=bit1, c=bit2; prime for 2,3,5,7
  assign prime = (op_val[1] & ~op_val[2]) | (op_val[2] & op_val[0]);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      op_id <= '0;
      op_val <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_value <= '0;
      bus.rsp_prime <= 1'b0;
      bus.eval_count <= '0;
      bus.prime_count <= '0;
    end else
      case (state)
        IDLE:
          if (|(bus.req_valid & bus.req_ready)) begin
            op_val <= win_val;
            op_id <= win;
            state <= EVAL;
          end
        EVAL: begin
          bus.rsp_value <= op_val;
          bus.rsp_id <= op_id;
          bus.rsp_prime <= prime;
          bus.rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP:
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.eval_count <= bus.eval_count + CNT_W'(bus.eval_count != '1);
            bus.prime_count <= bus.prime_count + CNT_W'(bus.rsp_prime && bus.prime_count != '1);
            ptr <= bus.rsp_id == ID_W'(N_REQ - 1) ? '0 : bus.rsp_id + 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_pnd_arbiter.sv
// tb_pnd_arbiter: table vectors, corner sequences and random traffic against a reference model
module tb_pnd_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pnd_arbiter_if #(.N_REQ(4), .CNT_W(8)) bus ();
  pnd_arbiter_if #(.N_REQ(4), .CNT_W(2)) bus2 ();
  pnd_arbiter #(.N_REQ(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pnd_arbiter #(.N_REQ(4), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  typedef struct {
    bit rst;
    logic [3:0] v;
    logic [11:0] vals;
    int id;
    logic [2:0] val;
    logic p;
  } vec_t;
  vec_t tbl[13];
  int checks = 0, errors = 0, cyc = 0, n2 = 0, last_rsp = 0;
  int m_ptr = 0, m_eval = 0, m_prime = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus2.rsp_valid && bus2.rsp_ready) n2 <= n2 + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic bit is_prime(input logic [2:0] v);
    return v == 3'd2 || v == 3'd3 || v == 3'd5 || v == 3'd7;
  endfunction
  function automatic int winner(input logic [3:0] v);
    for (int k = 0; k < 4; k++)
      if (v[2'((m_ptr + k) % 4)]) return (m_ptr + k) % 4;
    return 0;
  endfunction
  task automatic rst_seq(input int n);
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ptr = 0;
    m_eval = 0;
    m_prime = 0;
  endtask
  // one full request/response transaction; entered and left just after a rising edge
  task automatic xact(input logic [3:0] v, input logic [11:0] vals, input int stall, input bit early,
                      input bit scramble, output int gid, output logic [2:0] gval, output logic gp);
    int w;
    logic [2:0] ev;
    bus.req_valid = v;
    bus.req_value = vals;
    bus.rsp_ready = early;
    #1;
    w = winner(v);
    ev = 3'(vals >> (3 * w));
    chk("grant", 32'(bus.req_ready), 32'(4'b0001 << w));
    @(posedge clk); #1;
    if (scramble) begin
      bus.req_valid = 4'($urandom);
      bus.req_value = 12'($urandom);
    end
    #1;
    chk("eval_req_ready", 32'(bus.req_ready), 0);
    chk("eval_rsp_valid", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    for (int i = 0; i <= stall; i++) begin
      bus.rsp_ready = (i == stall);
      #1;
      chk("rsp_valid", 32'(bus.rsp_valid), 1);
      chk("rsp_id", 32'(bus.rsp_id), w);
      chk("rsp_value", 32'(bus.rsp_value), 32'(ev));
      chk("rsp_prime", 32'(bus.rsp_prime), 32'(is_prime(ev)));
      chk("resp_req_ready", 32'(bus.req_ready), 0);
      chk("eval_hold", 32'(bus.eval_count), m_eval);
      chk("prime_hold", 32'(bus.prime_count), m_prime);
      gid = int'(bus.rsp_id);
      gval = bus.rsp_value;
      gp = bus.rsp_prime;
      @(posedge clk); #1;
    end
    last_rsp = cyc;
    if (m_eval < 255) m_eval++;
    if (is_prime(ev) && m_prime < 255) m_prime++;
    m_ptr = (w + 1) % 4;
    bus.rsp_ready = 1'b0;
    #1;
    chk("rsp_valid_clear", 32'(bus.rsp_valid), 0);
    chk("eval_count", 32'(bus.eval_count), m_eval);
    chk("prime_count", 32'(bus.prime_count), m_prime);
  endtask
  initial begin
    int gid, prev;
    logic [2:0] gval;
    logic gp;
    logic [7:0] sweep_p;
    sweep_p = 8'b10101100;
    for (int i = 0; i < 8; i++)
      tbl[i] = '{i == 0, 4'b0100, 12'(i) << 6, 2, 3'(i), sweep_p[i]};
    tbl[8]  = '{1'b1, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 0, 3'd1, 1'b0};
    tbl[9]  = '{1'b0, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 1, 3'd2, 1'b1};
    tbl[10] = '{1'b0, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 2, 3'd3, 1'b1};
    tbl[11] = '{1'b0, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 3, 3'd4, 1'b0};
    tbl[12] = '{1'b0, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 0, 3'd1, 1'b0};
    bus.req_valid = 4'hF;
    bus.req_value = '0;
    bus.rsp_ready = 1'b0;
    bus2.req_valid = '0;
    bus2.req_value = '0;
    bus2.rsp_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
      chk("rst_rsp_value", 32'(bus.rsp_value), 0);
      chk("rst_rsp_prime", 32'(bus.rsp_prime), 0);
      chk("rst_eval", 32'(bus.eval_count), 0);
      chk("rst_prime", 32'(bus.prime_count), 0);
    end
    rst_n = 1'b1;
    #1;
    chk("first_grant", 32'(bus.req_ready), 32'h1);
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rst) rst_seq(2);
      prev = last_rsp;
      xact(tbl[i].v, tbl[i].vals, 0, 1'b1, 1'b0, gid, gval, gp);
      chk("tbl_id", gid, tbl[i].id);
      chk("tbl_value", 32'(gval), 32'(tbl[i].val));
      chk("tbl_prime", 32'(gp), 32'(tbl[i].p));
      if (!tbl[i].rst) chk("tbl_spacing", last_rsp - prev, 3);
      if (i == 7) begin
        chk("sweep_eval", 32'(bus.eval_count), 8);
        chk("sweep_prime", 32'(bus.prime_count), 4);
      end
    end
    xact(4'b0010, 12'(5) << 3, 5, 1'b0, 1'b0, gid, gval, gp);
    chk("bp_value", 32'(gval), 5);
    chk("bp_prime", 32'(gp), 1);
    for (int n = 0; n < 40; n++)
      xact(4'($urandom_range(1, 15)), 12'($urandom), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'b1, gid, gval, gp);
    bus.req_valid = 4'b0100;
    bus.req_value = 12'(3) << 6;
    bus.rsp_ready = 1'b0;
    #1;
    chk("single_grant", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 1);
    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_eval", 32'(bus.eval_count), 0);
    chk("mid_rst_prime", 32'(bus.prime_count), 0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    bus2.req_valid = 4'b0001;
    bus2.req_value = 12'd7;
    bus2.rsp_ready = 1'b1;
    for (int c = 0; c < 30 && n2 < 5; c++) begin
      @(posedge clk); #1;
    end
    bus2.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_responses", n2, 5);
    chk("sat_eval", 32'(bus2.eval_count), 3);
    chk("sat_prime", 32'(bus2.prime_count), 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
